// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive capture block.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_capture_if.sv
// Byte-stream valid/ready bus from the UART receiver to its consumer.
interface uart_rx_capture_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data_o;
  logic                      rx_valid_o;
  logic                      rx_ready_i;

  modport master (output rx_data_o, output rx_valid_o, input rx_ready_i);
  modport slave  (input rx_data_o, input rx_valid_o, output rx_ready_i);

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one wrap bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A simultaneous pop frees the slot this push lands in.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + PW'(1);
      end
      if (rd_en) begin
        rptr <= rptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and byte FIFO with overflow flag.
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 868,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_i,
  input  logic                  clr_i,
  uart_rx_capture_if.master     rx_bus,
  output logic                  frame_err_o,
  output logic                  overflow_o,
  output logic                  busy_o
);

  localparam int unsigned CW = $clog2(BIT_CYCLES);
  localparam int unsigned IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

  rx_state_e                 state;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      rx_meta;
  logic                      rxs;

  logic fifo_full;
  logic fifo_empty;
  logic push_c;
  logic pop_c;
  logic drop_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  // Push fires in the same cycle as the stop-bit sample so the FIFO sees it on that edge.
  assign push_c = (state == STOP) && (cnt == FULL_LAST) && rxs;
  assign pop_c  = rx_bus.rx_valid_o && rx_bus.rx_ready_i;
  assign drop_c = push_c && fifo_full && !pop_c;

  assign rx_bus.rx_valid_o = !fifo_empty;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (shreg),
    .rdata (rx_bus.rx_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
    end else if (drop_c) begin
      overflow_o <= 1'b1;
    end else if (clr_i) begin
      overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state  <= START;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rxs) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
            idx   <= idx + IW'(1);
            if (idx == IDX_LAST) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              state       <= BRK;
              frame_err_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BRK: begin
          // A held-low line must go idle before a new start bit is accepted.
          if (rxs) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture at BIT_CYCLES = 16, FIFO_DEPTH = 4.
module tb_uart_rx_capture;

  localparam int unsigned BITC = 16;
  localparam int LAT = 155;  // 154-cycle latency plus one for the drive-to-sample offset

  logic clk = 1'b0;
  logic rst_n;
  logic rx_i;
  logic clr_i;
  logic frame_err_o;
  logic overflow_o;
  logic busy_o;

  uart_rx_capture_if bus ();

  uart_rx_capture #(
    .BIT_CYCLES (BITC),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .clr_i       (clr_i),
    .rx_bus      (bus),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int assert_cnt = 0;
  int fail_cnt = 0;

  logic [7:0] got[$];
  int rise_cyc = -1;
  int valid_cycles = 0;
  int ferr_cycles = 0;
  int start_cyc = 0;
  logic prev_valid = 1'b0;

  // Record every accepted byte and pulse activity, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.rx_valid_o === 1'b1 && bus.rx_ready_i === 1'b1) got.push_back(bus.rx_data_o);
    if (bus.rx_valid_o === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    if (bus.rx_valid_o === 1'b1) valid_cycles++;
    if (frame_err_o === 1'b1) ferr_cycles++;
    prev_valid = bus.rx_valid_o;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v);
    rx_i = v;
    tick(BITC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
    rx_i = 1'b1;
  endtask

  task automatic clear_mon();
    got.delete();
    rise_cyc = -1;
    valid_cycles = 0;
    ferr_cycles = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_i = 1'b1; clr_i = 1'b0; bus.rx_ready_i = 1'b0;
    tick(3);
    assert_cnt++;
    if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy got %b want 0", busy_o); end
    assert_cnt++;
    if (bus.rx_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid got %b want 0", bus.rx_valid_o); end
    assert_cnt++;
    if (bus.rx_data_o !== 8'h00) begin fail_cnt++; $display("FAIL reset_data got %h want 00", bus.rx_data_o); end
    assert_cnt++;
    if (overflow_o !== 1'b0 || frame_err_o !== 1'b0) begin
      fail_cnt++; $display("FAIL reset_flags got ovf=%b ferr=%b want 0 0", overflow_o, frame_err_o);
    end
    rst_n = 1'b1;
    tick(5);
    assert_cnt++;
    if (busy_o !== 1'b0 || bus.rx_valid_o !== 1'b0) begin
      fail_cnt++; $display("FAIL post_reset_idle got busy=%b valid=%b want 0 0", busy_o, bus.rx_valid_o);
    end
  endtask

  task automatic test_single_frame();
    clear_mon();
    bus.rx_ready_i = 1'b1;
    send_frame(8'h55, 1'b1);
    tick(4);
    assert_cnt++;
    if (got.size() !== 1) begin fail_cnt++; $display("FAIL single_count got %0d want 1", got.size()); end
    else begin
      assert_cnt++;
      if (got[0] !== 8'h55) begin fail_cnt++; $display("FAIL single_data got %h want 55", got[0]); end
    end
    assert_cnt++;
    if (rise_cyc !== start_cyc + LAT) begin
      fail_cnt++; $display("FAIL single_latency got %0d want %0d", rise_cyc - start_cyc - 1, LAT - 1);
    end
    assert_cnt++;
    if (valid_cycles !== 1) begin fail_cnt++; $display("FAIL single_valid_width got %0d want 1", valid_cycles); end
    assert_cnt++;
    if (ferr_cycles !== 0) begin fail_cnt++; $display("FAIL single_ferr got %0d want 0", ferr_cycles); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_i = 1'b0;
    tick(3);
    assert_cnt++;
    if (busy_o !== 1'b1) begin fail_cnt++; $display("FAIL glitch_busy_up got %b want 1", busy_o); end
    rx_i = 1'b1;
    tick(20);
    assert_cnt++;
    if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL glitch_busy_down got %b want 0", busy_o); end
    assert_cnt++;
    if (valid_cycles !== 0 || ferr_cycles !== 0) begin
      fail_cnt++; $display("FAIL glitch_quiet got valid=%0d ferr=%0d want 0 0", valid_cycles, ferr_cycles);
    end
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_frame(8'hA3, 1'b0);
    rx_i = 1'b0;
    tick(40);
    assert_cnt++;
    if (busy_o !== 1'b1) begin fail_cnt++; $display("FAIL brk_busy got %b want 1", busy_o); end
    assert_cnt++;
    if (ferr_cycles !== 1) begin fail_cnt++; $display("FAIL brk_ferr_pulses got %0d want 1", ferr_cycles); end
    assert_cnt++;
    if (got.size() !== 0) begin fail_cnt++; $display("FAIL brk_no_push got %0d want 0", got.size()); end
    rx_i = 1'b1;
    tick(16);
    assert_cnt++;
    if (busy_o !== 1'b0) begin fail_cnt++; $display("FAIL brk_exit got %b want 0", busy_o); end
    send_frame(8'h0F, 1'b1);
    tick(4);
    assert_cnt++;
    if (got.size() !== 1) begin fail_cnt++; $display("FAIL after_brk_count got %0d want 1", got.size()); end
    else begin
      assert_cnt++;
      if (got[0] !== 8'h0F) begin fail_cnt++; $display("FAIL after_brk_data got %h want 0f", got[0]); end
    end
    assert_cnt++;
    if (rise_cyc !== start_cyc + LAT) begin
      fail_cnt++; $display("FAIL after_brk_latency got %0d want %0d", rise_cyc - start_cyc, LAT);
    end
    assert_cnt++;
    if (ferr_cycles !== 1) begin fail_cnt++; $display("FAIL after_brk_ferr got %0d want 1", ferr_cycles); end
  endtask

  task automatic test_overflow();
    clear_mon();
    bus.rx_ready_i = 1'b0;
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    tick(2);
    assert_cnt++;
    if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== 8'h01) begin
      fail_cnt++; $display("FAIL ovf_full_head got valid=%b data=%h want 1 01", bus.rx_valid_o, bus.rx_data_o);
    end
    assert_cnt++;
    if (overflow_o !== 1'b0) begin fail_cnt++; $display("FAIL ovf_not_yet got %b want 0", overflow_o); end
    send_frame(8'h05, 1'b1);
    tick(2);
    assert_cnt++;
    if (overflow_o !== 1'b1) begin fail_cnt++; $display("FAIL ovf_set got %b want 1", overflow_o); end
    assert_cnt++;
    if (bus.rx_data_o !== 8'h01) begin fail_cnt++; $display("FAIL ovf_head_stable got %h want 01", bus.rx_data_o); end
    bus.rx_ready_i = 1'b1;
    tick(4);
    bus.rx_ready_i = 1'b0;
    tick(2);
    assert_cnt++;
    if (got.size() !== 4) begin fail_cnt++; $display("FAIL ovf_drain_count got %0d want 4", got.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        assert_cnt++;
        if (got[i] !== 8'(i + 1)) begin fail_cnt++; $display("FAIL ovf_drain_%0d got %h want %h", i, got[i], 8'(i + 1)); end
      end
    end
    assert_cnt++;
    if (bus.rx_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      fail_cnt++; $display("FAIL ovf_after_drain got valid=%b ovf=%b want 0 1", bus.rx_valid_o, overflow_o);
    end
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    assert_cnt++;
    if (overflow_o !== 1'b0) begin fail_cnt++; $display("FAIL ovf_clear got %b want 0", overflow_o); end
  endtask

  task automatic test_push_pop_full();
    clear_mon();
    bus.rx_ready_i = 1'b0;
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    tick(2);
    assert_cnt++;
    if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== 8'h01) begin
      fail_cnt++; $display("FAIL pp_full_head got valid=%b data=%h want 1 01", bus.rx_valid_o, bus.rx_data_o);
    end
    fork
      send_frame(8'h05, 1'b1);
      begin
        tick(LAT - 1);
        bus.rx_ready_i = 1'b1;
        tick(1);
        bus.rx_ready_i = 1'b0;
      end
    join
    tick(2);
    assert_cnt++;
    if (overflow_o !== 1'b0) begin fail_cnt++; $display("FAIL pp_no_overflow got %b want 0", overflow_o); end
    assert_cnt++;
    if (got.size() !== 1 || bus.rx_data_o !== 8'h02) begin
      fail_cnt++; $display("FAIL pp_one_pop got count=%0d head=%h want 1 02", got.size(), bus.rx_data_o);
    end
    bus.rx_ready_i = 1'b1;
    tick(4);
    bus.rx_ready_i = 1'b0;
    tick(2);
    assert_cnt++;
    if (got.size() !== 5) begin fail_cnt++; $display("FAIL pp_drain_count got %0d want 5", got.size()); end
    else begin
      for (int i = 1; i < 5; i++) begin
        assert_cnt++;
        if (got[i] !== 8'(i + 1)) begin fail_cnt++; $display("FAIL pp_drain_%0d got %h want %h", i, got[i], 8'(i + 1)); end
      end
    end
    assert_cnt++;
    if (bus.rx_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL pp_empty got %b want 0", bus.rx_valid_o); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    bus.rx_ready_i = 1'b0;
    send_frame(8'h5A, 1'b1);
    tick(2);
    assert_cnt++;
    if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== 8'h5A) begin
      fail_cnt++; $display("FAIL rst_pre_head got valid=%b data=%h want 1 5a", bus.rx_valid_o, bus.rx_data_o);
    end
    rx_i = 1'b0;
    tick(BITC);
    rx_i = 1'b1;
    tick(20);
    assert_cnt++;
    if (busy_o !== 1'b1) begin fail_cnt++; $display("FAIL rst_in_data got busy=%b want 1", busy_o); end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    assert_cnt++;
    if (busy_o !== 1'b0 || bus.rx_valid_o !== 1'b0) begin
      fail_cnt++; $display("FAIL rst_mid_state got busy=%b valid=%b want 0 0", busy_o, bus.rx_valid_o);
    end
    assert_cnt++;
    if (bus.rx_data_o !== 8'h00) begin fail_cnt++; $display("FAIL rst_mid_data got %h want 00", bus.rx_data_o); end
    tick(40);
    clear_mon();
    bus.rx_ready_i = 1'b1;
    send_frame(8'hC3, 1'b1);
    tick(4);
    assert_cnt++;
    if (got.size() !== 1) begin fail_cnt++; $display("FAIL rst_after_count got %0d want 1", got.size()); end
    else begin
      assert_cnt++;
      if (got[0] !== 8'hC3) begin fail_cnt++; $display("FAIL rst_after_data got %h want c3", got[0]); end
    end
    assert_cnt++;
    if (rise_cyc !== start_cyc + LAT) begin
      fail_cnt++; $display("FAIL rst_after_latency got %0d want %0d", rise_cyc - start_cyc, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Synthesizable 8N1 UART receiver that consumes the SoC serial output (uart0_tx on fpioa[1]) and turns it into a byte stream with a valid/ready handshake.
- Used by the core-level simulation environment to reconstruct UART console traffic.
- Usable on FPGA as a loopback/debug receiver.
- Contains a bit-timing FSM followed by a small show-ahead byte FIFO.

Parameters:
- BIT_CYCLES, 868: clk cycles per bit (100 MHz / 115200). Even, >= 8.
- FIFO_DEPTH, 4: byte FIFO entries. Power of 2, >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_i  in  1  serial line, asynchronous to clk, idle high
- rx_data_o  out  8  head-of-FIFO byte
- rx_valid_o  out  1  FIFO not empty
- rx_ready_i  in  1  consumer accepts head byte when rx_valid_o && rx_ready_i
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overflow_o  out  1  sticky: a completed byte was dropped because the FIFO was full
- clr_i  in  1  clears overflow_o
- busy_o  out  1  FSM not in IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-low: the clock port is clk and the reset port is rst_n. All state is updated on posedge clk only.
- Reset values:
  - Both rx synchronizer flops = 1.
  - FSM = IDLE; bit counter, bit index and shift register = 0.
  - FIFO empty: rx_valid_o = 0, rx_data_o = 0.
  - frame_err_o = 0, overflow_o = 0, busy_o = 0.
- Reset mid-frame discards the partial byte and all FIFO contents.
- Input path: rx_i passes through a 2-flop synchronizer; the FSM sees only rxs (the second flop).
- FSM:
  - IDLE: when rxs == 0, go to START with cnt = 0.
  - START: cnt increments. At cnt == BIT_CYCLES/2-1:
    - rxs == 0 → DATA, cnt = 0, idx = 0.
    - rxs == 1 → treat as a glitch, return to IDLE.
  - DATA: at cnt == BIT_CYCLES-1, shift rxs into bit 7 of the shift register (LSB first), reset cnt, idx++. After the 8th bit, go to STOP.
  - STOP: at cnt == BIT_CYCLES-1, sample rxs:
    - 1 → push the byte, go to IDLE.
    - 0 → pulse frame_err_o for one cycle, do not push, go to BRK.
  - BRK: wait until rxs == 1, then go to IDLE. A held-low line is never re-decoded as bytes.
- Latency: rx_valid_o rises exactly 2 + BIT_CYCLES/2 + 9*BIT_CYCLES cycles after the first posedge at which rx_i is sampled low, assuming the FIFO was empty. This is 154 cycles at BIT_CYCLES = 16.
- FIFO behaviour:
  - Show-ahead: rx_data_o is valid whenever rx_valid_o = 1 and stays stable until popped.
  - Pop: rx_valid_o && rx_ready_i.
  - Push while full and no pop in the same cycle: the byte is dropped and overflow_o is set.
  - Push and pop in the same cycle while full: both are accepted; no overflow.
  - Push and pop in the same cycle while empty: push only; pop requires rx_valid_o, so it does not occur.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits wide. full and empty are derived from the extra pointer bit; pointers wrap naturally.
- overflow_o:
  - Set on a dropped push; cleared by clr_i.
  - If clr_i and a dropped push occur in the same cycle, set wins.
- rx_ready_i has no combinational path to rx_valid_o.
- busy_o = (state != IDLE), registered.

Decomposition:
- Package uart_pkg holds:
  - The FSM state typedef enum {IDLE, START, DATA, STOP, BRK}.
  - The constant UART_DATA_BITS = 8.
- One sub-module, sync_fifo, parameterised by width (8) and depth (FIFO_DEPTH). It provides push/pop/full/empty and head data.
- The FSM, synchronizer and overflow logic stay in uart_rx_capture.

Test Plan (BIT_CYCLES = 16, FIFO_DEPTH = 4):
- Frame 0x55 with rx_ready_i = 1 → rx_valid_o high for 1 cycle at cycle 154 with rx_data_o = 0x55; frame_err_o never asserts.
- rx_i low for 3 cycles, then high → START aborts at its mid-bit check; busy_o returns to 0; no rx_valid_o; no frame_err_o.
- Frame 0xA3 with the stop bit forced 0, line held low 40 cycles, then frame 0x0F → frame_err_o pulses once and 0xA3 is not pushed. The FSM stays in BRK until the line goes high, then 0x0F is received correctly.
- rx_ready_i = 0; send 0x01..0x05 → after the 4th byte rx_valid_o = 1 with head 0x01. The 5th byte is dropped and overflow_o = 1. Draining yields 0x01, 0x02, 0x03, 0x04; clr_i then clears overflow_o.
- FIFO full; assert rx_ready_i exactly in the cycle the 5th byte's stop bit completes → no overflow; drained order is 0x02..0x05.
- Assert rst_n = 0 for 1 cycle during DATA of a frame → next cycle busy_o = 0 and rx_valid_o = 0. The following clean frame 0xC3 is received correctly.
